alu_mul_seq: RTL and testbench

//  Multi-cycle 16-bit multiplier sequencer built on one shared Hack ALU instance.

---
 rtl/alu_mul_seq.sv | 116 +++++++++++
 tb/tb_alu_mul_seq.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: shift-and-add 16-bit multiplier sequencer driving one shared Hack ALU
module hack_alu (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic        zx,
    input  logic        nx,
    input  logic        zy,
    input  logic        ny,
    input  logic        f,
    input  logic        no,
    output logic [15:0] out
);
    logic [15:0] xa, xb, ya, yb, r;
    // Classic Hack ALU: optional zero/negate per operand, add or and, optional negate of result
    always_comb begin
        xa  = zx ? 16'h0000 : x;
        xb  = nx ? ~xa : xa;
        ya  = zy ? 16'h0000 : y;
        yb  = ny ? ~ya : ya;
        r   = f ? xb + yb : xb & yb;
        out = no ? ~r : r;
    end
endmodule

module alu_mul_seq #(
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] product,
    output logic        zr,
    output logic        ng,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, ACC, DBL, DONE} state_t;
    localparam logic [5:0] ADD  = 6'b000010;
    localparam logic [5:0] ZERO = 6'b101010;

    state_t      state;
    logic [15:0] acc, mcand, mplr, alu_x, alu_out;
    logic [3:0]  cnt;
    logic [5:0]  ctrl;

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == DONE);
    assign busy      = (state == ACC) || (state == DBL);
    assign alu_x     = (state == ACC) ? acc : mcand;
    assign ctrl      = busy ? ADD : ZERO;

    hack_alu u_alu (
        .x   (alu_x),
        .y   (mcand),
        .zx  (ctrl[5]),
        .nx  (ctrl[4]),
        .zy  (ctrl[3]),
        .ny  (ctrl[2]),
        .f   (ctrl[1]),
        .no  (ctrl[0]),
        .out (alu_out)
    );

    // Sequencer: ACC adds the multiplicand when the low multiplier bit is set, DBL doubles it and shifts the multiplier
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            acc     <= '0;
            mcand   <= '0;
            mplr    <= '0;
            cnt     <= '0;
            product <= '0;
            zr      <= 1'b1;
            ng      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    acc   <= '0;
                    mcand <= a;
                    mplr  <= b;
                    cnt   <= '0;
                    if (EARLY_EXIT && b == 16'h0000) begin
                        state   <= DONE;
                        product <= '0;
                        zr      <= 1'b1;
                        ng      <= 1'b0;
                    end else begin
                        state <= ACC;
                    end
                end
                ACC: begin
                    if (mplr[0]) acc <= alu_out;
                    state <= DBL;
                end
                DBL: begin
                    mcand <= alu_out;
                    mplr  <= mplr >> 1;
                    cnt   <= cnt + 4'd1;
                    if (cnt == 4'd15 || (EARLY_EXIT && (mplr >> 1) == 16'h0000)) begin
                        state   <= DONE;
                        product <= acc;
                        zr      <= (acc == 16'h0000);
                        ng      <= acc[15];
                    end else begin
                        state <= ACC;
                    end
                end
                default: if (rsp_ready) state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_mul_seq.sv
// tb_alu_mul_seq: directed scoreboard bench for both EARLY_EXIT settings
module tb_alu_mul_seq;
    typedef struct packed {
        logic [15:0] p;
        int          lat;
        int          bsy;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] a = '0, b = '0;
    logic [1:0]  req_valid = '0, rsp_ready = '0;
    logic [1:0]  req_ready, rsp_valid, zr, ng, busy;
    logic [15:0] product [2];
    exp_t        sb [$];
    int          vectors = 0, errors = 0;

    always #5 clk = ~clk;

    alu_mul_seq #(.EARLY_EXIT(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .a(a), .b(b), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .product(product[0]), .zr(zr[0]), .ng(ng[0]), .busy(busy[0])
    );

    alu_mul_seq #(.EARLY_EXIT(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .a(a), .b(b), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .product(product[1]), .zr(zr[1]), .ng(ng[1]), .busy(busy[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Edge index after which rsp_valid is seen; b==0 with early exit lands in DONE on the accept edge itself
    function automatic int lat(input logic [15:0] bv, input bit ee);
        int k = -1;
        for (int i = 0; i < 16; i++) if (bv[i]) k = i;
        if (!ee) return 32;
        if (k < 0) return 0;
        return 2 * (k + 1);
    endfunction

    task automatic op(input logic [15:0] ta, input logic [15:0] tb_, input int s, input int hold);
        exp_t        e;
        int          n = 0, busy_n = 0, rr_n = 0, bad = 0;
        logic [15:0] p0;
        check("idle_ready", 32'(req_ready[s]), 32'd1);
        a = ta;
        b = tb_;
        req_valid[s] = 1'b1;
        e.p   = ta * tb_;
        e.lat = lat(tb_, s == 1);
        e.bsy = (s == 1 && tb_ == 16'h0000) ? 0 : e.lat;
        @(posedge clk);
        sb.push_back(e);
        @(negedge clk);
        req_valid[s] = 1'b0;
        while (!rsp_valid[s] && n < 100) begin
            busy_n += int'(busy[s]);
            rr_n   += int'(req_ready[s]);
            a = 16'($urandom);
            b = 16'($urandom);
            @(negedge clk);
            n++;
        end
        check("rsp_valid", 32'(rsp_valid[s]), 32'd1);
        check("sb_depth", 32'(sb.size()), 32'd1);
        e = sb.pop_front();
        check("latency", 32'(n), 32'(e.lat));
        check("busy_cycles", 32'(busy_n), 32'(e.bsy));
        check("ready_while_busy", 32'(rr_n), 32'd0);
        check("product", 32'(product[s]), 32'(e.p));
        check("zr", 32'(zr[s]), 32'(e.p == 16'h0000));
        check("ng", 32'(ng[s]), 32'(e.p[15]));
        p0 = product[s];
        for (int i = 0; i < hold; i++) begin
            req_valid[s] = 1'b1;
            a = 16'($urandom);
            b = 16'($urandom);
            @(negedge clk);
            if (product[s] !== p0 || !rsp_valid[s] || req_ready[s]) bad++;
        end
        if (hold > 0) check("hold_stable", 32'(bad), 32'd0);
        rsp_ready[s] = 1'b1;
        @(negedge clk);
        rsp_ready[s] = 1'b0;
        req_valid[s] = 1'b0;
        check("release_ready", 32'(req_ready[s]), 32'd1);
        check("release_idle", 32'(busy[s] | rsp_valid[s]), 32'd0);
    endtask

    initial begin
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready[1]), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid[1]), 32'd0);
        check("rst_busy", 32'(busy[1]), 32'd0);
        check("rst_zr", 32'(zr[1]), 32'd1);
        check("rst_ng", 32'(ng[1]), 32'd0);
        check("rst_product", 32'(product[1]), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        op(16'd42, 16'd129, 1, 0);
        check("p_42x129", 32'(product[1]), 32'h152A);
        op(16'd3, 16'd5, 1, 0);
        op(16'hFFFF, 16'hFFFF, 1, 0);
        check("p_ffff_sq", 32'(product[1]), 32'h0001);
        op(16'h8000, 16'd1, 1, 0);
        check("ng_8000", 32'(ng[1]), 32'd1);
        op(16'h1248, 16'd0, 1, 0);
        op(16'h1248, 16'd0, 0, 0);
        op(16'd3, 16'd5, 0, 0);
        op(16'h00C3, 16'h0011, 1, 10);
        a = 16'd7;
        b = 16'd9;
        req_valid[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid[1] = 1'b0;
        @(negedge clk);
        check("in_dbl_busy", 32'(busy[1]), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy[1]), 32'd0);
        check("abort_rsp_valid", 32'(rsp_valid[1]), 32'd0);
        check("abort_req_ready", 32'(req_ready[1]), 32'd1);
        check("abort_product", 32'(product[1]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        op(16'd7, 16'd9, 1, 0);
        check("p_7x9", 32'(product[1]), 32'h003F);
        for (int i = 0; i < 4; i++) op(16'($urandom), 16'($urandom), 1, 0);
        op(16'($urandom), 16'($urandom), 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
